fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side drain engine for the team's `synchronous_fifo`. It watches the FIFO's `empty` flag, issues `r_en` pulses, captures `data_out` one cycle later, and presents the words as a valid/ready stream with frame framing (`m_last`). It includes a 2-entry output skid buffer, so a continuously ready sink gets one word per clock while the FIFO is non-empty.

## Interface
- `DATA_WIDTH`, default 8: word width; matches the FIFO `data_in`/`data_out` width.
- `FRAME_LEN`, default 4: words per frame, must be at least 1; `m_last` marks word `FRAME_LEN-1`.
- `COUNT_WIDTH`, default 8: width of `frame_count`.

Ports:
- `clk`  in  1: single clock, rising edge; the FIFO uses the same clock.
- `rst_n`  in  1: asynchronous, active-high reset. The name follows the codebase; the polarity is high.
- `en`  in  1: when high, new FIFO reads may be issued.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_rdata`  in  DATA_WIDTH: FIFO `data_out`. Valid in the cycle after `fifo_r_en` was sampled high.
- `fifo_r_en`  out  1: FIFO `r_en`. Combinational output.
- `m_valid`  out  1: output word available.
- `m_ready`  in  1: sink accepts the word.
- `m_data`  out  DATA_WIDTH: output word, taken from the head of the skid buffer.
- `m_last`  out  1: the current `m_data` is the last word of its frame.
- `frame_count`  out  COUNT_WIDTH: number of completed frames; wraps modulo 2^COUNT_WIDTH.
- `busy`  out  1: high when a word is buffered or a read is in flight.

## Operation
- State:
  - `occ` (0..2): skid-buffer occupancy.
  - `inflight` (1 bit): a read was issued last cycle.
  - `beat` (0..FRAME_LEN-1): position of the head word within its frame.
  - `frame_count`.
- A handshake (`pop`) occurs when `m_valid && m_ready`.
- `fifo_r_en = en && !fifo_empty && (occ + inflight - pop) < 2`. This is combinational from `m_ready`, which is intentional: it allows full throughput.
- Capture: if `inflight` is high, `fifo_rdata` is written into the skid buffer this cycle. Order is FIFO-preserving.
- Then `inflight` takes the value of `fifo_r_en`.
- `occ_next = occ + inflight - pop`. By construction, `occ_next` never exceeds 2. An overflow is an assertion failure.
- `m_valid = (occ != 0)`.
- `m_data` is the oldest buffered word.
- `m_last = m_valid && (beat == FRAME_LEN-1)`.
- On each `pop`:
  - If `beat == FRAME_LEN-1`, `beat` wraps to 0 and `frame_count` increments.
  - Otherwise `beat` increments.
  - With `FRAME_LEN=1`, every word is last.
- `en` low:
  - Stops new reads only.
  - A word already in flight is still captured.
  - Buffered words still drain.
- `busy = (occ != 0) || inflight`.
- Simultaneous capture and pop with `occ=1`:
  - The head is replaced by the new word.
  - `occ` stays 1.
  - There is no bubble.
- Reset, asynchronous and at any time:
  - All outputs and state clear: `occ=0`, `inflight=0`, `beat=0`, `frame_count=0`, `m_valid=0`, `m_last=0`, `m_data=0`, `busy=0`.
  - `fifo_r_en` is 0 while reset is asserted.
  - A word in flight at reset is lost, because the FIFO pointer has already advanced. The FIFO is reset together with this block.

## Timing
- Latency:
  - `fifo_r_en` is high in cycle N.
  - The word is captured at the end of N+1.
  - `m_valid` is high in N+2.
  - Empty-to-output latency is therefore 2 cycles.
- Throughput: with `m_ready` held high and the FIFO non-empty, `fifo_r_en` is high every cycle and `m_valid` is high every cycle after the initial 2-cycle fill.
- Backpressure: `m_ready` low with `occ=2` forces `fifo_r_en` low in the same cycle.
- `m_valid`, `m_data` and `m_last` are stable while `m_valid && !m_ready`.

## Test plan
- Basic drain: reset, preload the FIFO with 0x01..0x08, hold `en=1` and `m_ready=1`.
  - `fifo_r_en` is high for 8 consecutive cycles.
  - `m_data` shows 0x01..0x08 on consecutive cycles, starting 2 cycles after the first `r_en`.
  - `m_last` is high on 0x04 and 0x08.
  - `frame_count` ends at 2.
- Backpressure: load 6 words, hold `m_ready=0`.
  - Exactly 2 reads are issued, and `occ` reaches 2.
  - `m_data` holds 0x01.
  - Toggle `m_ready` 1/0: the output order stays 0x01..0x06 with no loss or duplication.
- Empty boundary: FIFO holds 1 word.
  - One `r_en` is issued.
  - `fifo_r_en` is never high while `fifo_empty=1`.
  - `busy` falls 1 cycle after the word pops.
- Enable gating: deassert `en` in the same cycle as an `r_en` with 5 words queued.
  - The in-flight word is still delivered.
  - No further `r_en` until `en` returns high.
- Reset mid-frame: assert `rst_n` high after 2 of 4 frame words have popped.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release with the FIFO refilled, `m_last` lands on the 4th new word.
- Wrap: set `COUNT_WIDTH=2`, `FRAME_LEN=1`, send 5 words.
  - `frame_count` sequence is 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO into a valid/ready stream.
// A read issued in cycle N returns data in N+1; that word is captured into a
// 2-entry skid buffer at the end of N+1 and is presented in N+2. Words are
// grouped into frames of FRAME_LEN, with m_last marking the final word of each
// frame and frame_count counting completed frames.
// Note: rst_n is an asynchronous, ACTIVE-HIGH reset. The name is historical.

module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_LEN   = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rdata,
    output logic                   fifo_r_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_last,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic                   busy
);

    // A beat counter needs at least one bit, even when FRAME_LEN is 1.
    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    // Registered state
    logic [1:0]             occ_r;
    logic                   inflight_r;
    logic [BEAT_W-1:0]      beat_r;
    logic [COUNT_WIDTH-1:0] frame_count_r;
    logic [DATA_WIDTH-1:0]  buf0_r;   // head of the skid buffer (oldest word)
    logic [DATA_WIDTH-1:0]  buf1_r;   // second entry

    // Combinational next-state and control
    logic                   m_valid_s;
    logic                   pop_s;
    logic [2:0]             occ_sum_s;
    logic [1:0]             occ_next_s;
    logic [1:0]             wr_pos_s;
    logic                   rd_issue_s;
    logic [DATA_WIDTH-1:0]  buf0_next_s;
    logic [DATA_WIDTH-1:0]  buf1_next_s;
    logic [BEAT_W-1:0]      beat_next_s;
    logic [COUNT_WIDTH-1:0] frame_count_next_s;

    assign m_valid_s = (occ_r != 2'd0);

    // Handshake, occupancy arithmetic, and the read-issue decision.
    always_comb begin
        pop_s      = m_valid_s && m_ready;
        // occ + inflight - pop. Because pop implies occ != 0, this never underflows.
        occ_sum_s  = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        occ_next_s = occ_sum_s[1:0];
        // Slot that receives a captured word, after this cycle's pop has been removed.
        wr_pos_s   = occ_r - {1'b0, pop_s};
        // Depends combinationally on m_ready, so a ready sink is fed every cycle.
        rd_issue_s = !rst_n && en && !fifo_empty && (occ_sum_s < 3'd2);
    end

    // Skid-buffer data movement: shift the buffer on pop, then write the captured word.
    always_comb begin
        buf0_next_s = buf0_r;
        buf1_next_s = buf1_r;
        if (pop_s && (occ_r == 2'd2)) begin
            buf0_next_s = buf1_r;
        end else begin
            buf0_next_s = buf0_r;
        end
        if (inflight_r) begin
            case (wr_pos_s)
                2'd0:    buf0_next_s = fifo_rdata;
                2'd1:    buf1_next_s = fifo_rdata;
                default: buf1_next_s = buf1_r;   // overflow, cannot occur; flagged by the checker
            endcase
        end else begin
            buf1_next_s = buf1_r;
        end
    end

    // Frame position and the completed-frame counter advance on each pop.
    always_comb begin
        beat_next_s        = beat_r;
        frame_count_next_s = frame_count_r;
        if (pop_s) begin
            if (beat_r == LAST_BEAT) begin
                beat_next_s        = {BEAT_W{1'b0}};
                frame_count_next_s = frame_count_r + COUNT_WIDTH'(1);
            end else begin
                beat_next_s        = beat_r + BEAT_W'(1);
                frame_count_next_s = frame_count_r;
            end
        end else begin
            beat_next_s        = beat_r;
            frame_count_next_s = frame_count_r;
        end
    end

    // State registers. Reset is asynchronous and clears everything; a word
    // that is in flight at reset is dropped.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            occ_r         <= 2'd0;
            inflight_r    <= 1'b0;
            beat_r        <= {BEAT_W{1'b0}};
            frame_count_r <= {COUNT_WIDTH{1'b0}};
            buf0_r        <= {DATA_WIDTH{1'b0}};
            buf1_r        <= {DATA_WIDTH{1'b0}};
        end else begin
            occ_r         <= occ_next_s;
            inflight_r    <= rd_issue_s;
            beat_r        <= beat_next_s;
            frame_count_r <= frame_count_next_s;
            buf0_r        <= buf0_next_s;
            buf1_r        <= buf1_next_s;
        end
    end

    assign fifo_r_en   = rd_issue_s;
    assign m_valid     = m_valid_s;
    assign m_data      = buf0_r;
    assign m_last      = m_valid_s && (beat_r == LAST_BEAT);
    assign frame_count = frame_count_r;
    assign busy        = m_valid_s || inflight_r;

    fifo_stream_reader_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk        (clk),
        .rst        (rst_n),
        .occ_sum    (occ_sum_s),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (rd_issue_s),
        .m_valid    (m_valid_s),
        .m_ready    (m_ready),
        .m_data     (buf0_r),
        .m_last     (m_last)
    );

endmodule

// Protocol checker for fifo_stream_reader. It contains only assertions and
// drives no outputs.
module fifo_stream_reader_chk #(
    parameter int DATA_WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    input logic [2:0]            occ_sum,
    input logic                  en,
    input logic                  fifo_empty,
    input logic                  fifo_r_en,
    input logic                  m_valid,
    input logic                  m_ready,
    input logic [DATA_WIDTH-1:0] m_data,
    input logic                  m_last
);

    // The skid buffer must never need a third slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        occ_sum <= 3'd2);

    // A read is never issued to an empty FIFO.
    a_no_read_empty: assert property (@(posedge clk) disable iff (rst)
        fifo_r_en |-> !fifo_empty);

    // Reads are only issued while enabled.
    a_read_needs_en: assert property (@(posedge clk) disable iff (rst)
        fifo_r_en |-> en);

    // A stalled output holds its word and framing.
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

    // m_last is qualified by m_valid.
    a_last_valid: assert property (@(posedge clk) disable iff (rst)
        m_last |-> m_valid);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader. Behavioural FIFO models feed two DUTs:
// the default configuration, and FRAME_LEN=1 with COUNT_WIDTH=2 to exercise
// counter wrap. Stimulus pushes the expected words into a scoreboard queue,
// and a negedge monitor pops the queue and compares on every handshake.
module tb_fifo_stream_reader;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, fifo_empty, fifo_r_en, m_valid, m_ready, m_last, busy;
    logic [7:0] fifo_rdata, m_data, frame_count;

    logic       w_en, w_fifo_empty, w_fifo_r_en, w_m_valid, w_m_ready, w_m_last, w_busy;
    logic [7:0] w_fifo_rdata, w_m_data;
    logic [1:0] w_frame_count;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // Behavioural FIFO for the main DUT.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    // Behavioural FIFO for the wrap DUT.
    logic [7:0] w_mem [0:15];
    int w_wr = 0;
    int w_rd = 0;

    exp_t       exp_q[$];
    logic [7:0] w_exp_q[$];
    int         ren_cyc_q[$];
    int         pop_cyc_q[$];
    logic [1:0] w_fc_seq[$];
    int         push_beat;
    int         exp_fc;
    int         ren_empty_viol = 0;
    logic       stall_prev;
    logic [7:0] hold_data;
    logic       hold_last;
    logic [1:0] w_fc_prev;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .FRAME_LEN(4), .COUNT_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_r_en(fifo_r_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .frame_count(frame_count), .busy(busy)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .FRAME_LEN(1), .COUNT_WIDTH(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(w_en), .fifo_empty(w_fifo_empty),
        .fifo_rdata(w_fifo_rdata), .fifo_r_en(w_fifo_r_en), .m_valid(w_m_valid),
        .m_ready(w_m_ready), .m_data(w_m_data), .m_last(w_m_last),
        .frame_count(w_frame_count), .busy(w_busy)
    );

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign w_fifo_empty = (w_wr == w_rd);

    // Both FIFO models: reads take effect at the clock edge, and data_out is valid in the next cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            rd_ptr       <= wr_ptr;
            fifo_rdata   <= 8'h00;
            w_rd         <= w_wr;
            w_fifo_rdata <= 8'h00;
        end else begin
            if (fifo_r_en && !fifo_empty) begin
                fifo_rdata <= mem[rd_ptr % 64];
                rd_ptr     <= rd_ptr + 1;
            end
            if (w_fifo_r_en && !w_fifo_empty) begin
                w_fifo_rdata <= w_mem[w_rd % 16];
                w_rd         <= w_rd + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: compares each handshake against the queue and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_q.delete();
            w_exp_q.delete();
            exp_fc     <= 0;
            stall_prev <= 1'b0;
            w_fc_prev  <= 2'd0;
        end else begin
            if (fifo_r_en) begin
                ren_cyc_q.push_back(cyc);
                if (fifo_empty) ren_empty_viol <= ren_empty_viol + 1;
            end
            if (stall_prev) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", {24'd0, m_data}, {24'd0, hold_data});
                chk("hold_last", {31'd0, m_last}, {31'd0, hold_last});
            end
            if (m_valid && m_ready) begin
                pop_cyc_q.push_back(cyc);
                chk("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    chk("data", {24'd0, m_data}, {24'd0, exp_q[0].data});
                    chk("last", {31'd0, m_last}, {31'd0, exp_q[0].last});
                    chk("frame_count", {24'd0, frame_count}, exp_fc);
                    if (exp_q[0].last) exp_fc <= exp_fc + 1;
                    void'(exp_q.pop_front());
                end
            end
            stall_prev <= m_valid && !m_ready;
            hold_data  <= m_data;
            hold_last  <= m_last;
            if (w_m_valid && w_m_ready) begin
                chk("wrap_has_entry", {31'd0, w_exp_q.size() != 0}, 32'd1);
                if (w_exp_q.size() != 0) begin
                    chk("wrap_data", {24'd0, w_m_data}, {24'd0, w_exp_q[0]});
                    chk("wrap_last", {31'd0, w_m_last}, 32'd1);
                    void'(w_exp_q.pop_front());
                end
            end
            if (w_frame_count != w_fc_prev) w_fc_seq.push_back(w_frame_count);
            w_fc_prev <= w_frame_count;
        end
    end

    task automatic push_word(input logic [7:0] d);
        exp_t e;
        mem[wr_ptr % 64] = d;
        wr_ptr = wr_ptr + 1;
        e.data = d;
        e.last = (push_beat == 3);
        exp_q.push_back(e);
        push_beat = (push_beat == 3) ? 0 : push_beat + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        push_beat = 0;
    endtask

    int ren_base, pop_base;
    logic found;
    logic [1:0] fc_exp [0:4];

    initial begin
        // Reset state, checked before any clock edge.
        en = 1'b0; m_ready = 1'b0; w_en = 1'b0; w_m_ready = 1'b0;
        push_beat = 0;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        en = 1'b1;
        push_word(8'hAA);            // FIFO non-empty while reset is held
        #1;
        chk("rst_ren", {31'd0, fifo_r_en}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fc", {24'd0, frame_count}, 32'd0);
        en = 1'b0;

        // Test 1: basic drain of 8 words.
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        m_ready = 1'b1;
        ren_base = ren_cyc_q.size();
        pop_base = pop_cyc_q.size();
        en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t1_ren_count", ren_cyc_q.size() - ren_base, 32'd8);
        chk("t1_pop_count", pop_cyc_q.size() - pop_base, 32'd8);
        if (ren_cyc_q.size() >= ren_base + 8 && pop_cyc_q.size() >= pop_base + 8) begin
            chk("t1_ren_consec", ren_cyc_q[ren_base + 7] - ren_cyc_q[ren_base], 32'd7);
            chk("t1_latency", pop_cyc_q[pop_base] - ren_cyc_q[ren_base], 32'd2);
            chk("t1_pop_consec", pop_cyc_q[pop_base + 7] - pop_cyc_q[pop_base], 32'd7);
        end
        chk("t1_frames", {24'd0, frame_count}, 32'd2);
        chk("t1_sb_drained", exp_q.size(), 32'd0);

        // Test 2: backpressure, then toggled ready.
        en = 1'b0; m_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 6; i++) push_word(8'(i));
        ren_base = ren_cyc_q.size();
        pop_base = pop_cyc_q.size();
        en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t2_ren_count", ren_cyc_q.size() - ren_base, 32'd2);
        chk("t2_valid", {31'd0, m_valid}, 32'd1);
        chk("t2_head", {24'd0, m_data}, 32'd1);
        chk("t2_ren_blocked", {31'd0, fifo_r_en}, 32'd0);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            m_ready = ~m_ready;
            if (exp_q.size() == 0 && !busy) break;
        end
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t2_pop_count", pop_cyc_q.size() - pop_base, 32'd6);
        chk("t2_frames", {24'd0, frame_count}, 32'd1);
        chk("t2_sb_drained", exp_q.size(), 32'd0);

        // Test 3: a single word reaches the empty boundary.
        en = 1'b0;
        do_reset();
        m_ready = 1'b1;
        en = 1'b1;
        ren_base = ren_cyc_q.size();
        push_word(8'h33);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                found = 1'b1;
                break;
            end
        end
        chk("t3_pop_seen", {31'd0, found}, 32'd1);
        if (found) begin
            chk("t3_busy_at_pop", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("t3_busy_after", {31'd0, busy}, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t3_ren_count", ren_cyc_q.size() - ren_base, 32'd1);

        // Test 4: enable gating with one read in flight.
        en = 1'b0;
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push_word(8'h40 + 8'(i));
        ren_base = ren_cyc_q.size();
        pop_base = pop_cyc_q.size();
        @(posedge clk); #1; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t4_ren_gated", ren_cyc_q.size() - ren_base, 32'd1);
        chk("t4_inflight_delivered", pop_cyc_q.size() - pop_base, 32'd1);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        en = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("t4_ren_total", ren_cyc_q.size() - ren_base, 32'd5);
        chk("t4_pop_total", pop_cyc_q.size() - pop_base, 32'd5);
        chk("t4_sb_drained", exp_q.size(), 32'd0);

        // Test 5: reset asserted in the middle of a frame.
        en = 1'b0;
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(8'h50 + 8'(i));
        en = 1'b1;
        pop_base = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) pop_base++;
            if (pop_base == 2) break;
        end
        #1;
        chk("t5_valid_before", {31'd0, m_valid}, 32'd1);
        #1 rst_n = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_rst_last", {31'd0, m_last}, 32'd0);
        chk("t5_rst_data", {24'd0, m_data}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_ren", {31'd0, fifo_r_en}, 32'd0);
        chk("t5_rst_fc", {24'd0, frame_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        push_beat = 0;
        for (int i = 1; i <= 4; i++) push_word(8'h60 + 8'(i));
        repeat (12) @(posedge clk);
        #1;
        chk("t5_frames", {24'd0, frame_count}, 32'd1);
        chk("t5_sb_drained", exp_q.size(), 32'd0);

        // Test 6: frame_count wraps with COUNT_WIDTH=2 and FRAME_LEN=1.
        en = 1'b0;
        fc_exp[0] = 2'd1; fc_exp[1] = 2'd2; fc_exp[2] = 2'd3; fc_exp[3] = 2'd0; fc_exp[4] = 2'd1;
        w_m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            w_mem[w_wr % 16] = 8'h70 + 8'(i);
            w_wr = w_wr + 1;
            w_exp_q.push_back(8'h70 + 8'(i));
        end
        w_en = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("t6_fc_changes", w_fc_seq.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < w_fc_seq.size()) chk("t6_fc_seq", {30'd0, w_fc_seq[i]}, {30'd0, fc_exp[i]});
        end
        chk("t6_sb_drained", w_exp_q.size(), 32'd0);

        chk("no_ren_while_empty", ren_empty_viol, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
